// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
//   arb_state_t  : debug-path FSM state (IDLE waits for a grant, RESP holds a response)
//   DMEM_ADDR_W  : default dmem word-address width
//   DMEM_DATA_W  : default dmem data width
package dmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    localparam int unsigned DMEM_ADDR_W = 6;
    localparam int unsigned DMEM_DATA_W = 64;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating counter of cycles a debug request has been blocked by the CPU.
// Ports:
//   clk, reset : clock, async active-low reset
//   clr        : clear to zero (has priority over inc)
//   inc        : count up by one, holding at MAX_WAIT
//   sat_c      : combinational flag, count has reached MAX_WAIT
module arb_wait_counter #(
    parameter int unsigned MAX_WAIT = 4,
    localparam int unsigned CNT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic sat_c
);

    logic [CNT_W-1:0] count;

    assign sat_c = (count == CNT_W'(MAX_WAIT));

    // Count register; saturation keeps it from wrapping past MAX_WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU datapath and a debug/DMA port.
// The CPU has fixed priority; a debug request blocked for MAX_WAIT cycles is forced
// through for one cycle, stalling the CPU. Debug responses are registered and held
// until consumed.
// Ports:
//   clk, reset                      : clock, async active-low reset
//   cpu_memRead/cpu_memWrite        : datapath access enables
//   cpu_addr/cpu_writeData          : datapath byte address and store data
//   cpu_readData/cpu_stall          : load data and stall to the datapath (combinational)
//   dbg_req_valid/ready/write/addr/wdata : debug request channel (ready is combinational)
//   dbg_rsp_valid/ready/data        : debug response channel (valid/data registered)
//   mem_writeEnable/readEnable/address/writeData : combinational drive to dmem
//   mem_readData                    : dmem combinational read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned N        = DMEM_DATA_W,
    parameter int unsigned ADDR_W   = DMEM_ADDR_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_memRead,
    input  logic              cpu_memWrite,
    input  logic [N-1:0]      cpu_addr,
    input  logic [N-1:0]      cpu_writeData,
    output logic [N-1:0]      cpu_readData,
    output logic              cpu_stall,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_write,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [N-1:0]      dbg_req_wdata,
    output logic              dbg_rsp_valid,
    input  logic              dbg_rsp_ready,
    output logic [N-1:0]      dbg_rsp_data,
    output logic              mem_writeEnable,
    output logic              mem_readEnable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [N-1:0]      mem_writeData,
    input  logic [N-1:0]      mem_readData
);

    arb_state_t        state;
    arb_state_t        stateNext;
    logic              cpuActive;
    logic [ADDR_W-1:0] cpuWordAddr;
    logic              waitSat;
    logic              grant;
    logic              waitClr;
    logic              waitInc;
    logic              unusedAddrBits;

    // CPU byte address -> word address; byte offset and high bits are don't-care.
    assign cpuWordAddr    = cpu_addr[ADDR_W+2:3];
    assign unusedAddrBits = ^{cpu_addr[N-1:ADDR_W+3], cpu_addr[2:0]};
    assign cpuActive      = cpu_memRead | cpu_memWrite;

    // Debug wins when the CPU is idle or the debug port has waited long enough.
    assign grant = (state == IDLE) && dbg_req_valid && (!cpuActive || waitSat);
    assign dbg_req_ready = grant;

    // Blocked-cycle counter; holds while a response is outstanding.
    assign waitClr = grant || !dbg_req_valid;
    assign waitInc = dbg_req_valid && !grant && (state == IDLE);

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_waitCounter (
        .clk   (clk),
        .reset (reset),
        .clr   (waitClr),
        .inc   (waitInc),
        .sat_c (waitSat)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (grant)         stateNext = RESP;
            RESP:    if (dbg_rsp_ready) stateNext = IDLE;
            default:                    stateNext = IDLE;
        endcase
    end

    // Memory port mux; the loser of a conflict simply retries next cycle.
    always_comb begin
        mem_writeEnable = cpu_memWrite;
        mem_readEnable  = cpu_memRead;
        mem_address     = cpuWordAddr;
        mem_writeData   = cpu_writeData;
        cpu_readData    = mem_readData;
        cpu_stall       = 1'b0;
        if (grant) begin
            mem_writeEnable = dbg_req_write;
            mem_readEnable  = !dbg_req_write;
            mem_address     = dbg_req_addr;
            mem_writeData   = dbg_req_wdata;
            cpu_readData    = '0;
            cpu_stall       = cpuActive;
        end
    end

    // Debug response register, captured on grant and held until consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_data  <= '0;
        end else if (grant) begin
            dbg_rsp_valid <= 1'b1;
            dbg_rsp_data  <= dbg_req_write ? '0 : mem_readData;
        end else if ((state == RESP) && dbg_rsp_ready) begin
            dbg_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level reference model of the arbiter and memory.
module tb_dmem_arbiter;

    localparam int unsigned N        = 64;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned DEPTH    = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpuRead, cpuWrite;
    logic [N-1:0]      cpuAddr, cpuWdata;
    logic [N-1:0]      cpu_readData;
    logic              cpu_stall;
    logic              dbgValid, dbgWrite;
    logic [ADDR_W-1:0] dbgAddr;
    logic [N-1:0]      dbgWdata;
    logic              dbg_req_ready, dbg_rsp_valid;
    logic              rspReady;
    logic [N-1:0]      dbg_rsp_data;
    logic              mem_writeEnable, mem_readEnable;
    logic [ADDR_W-1:0] mem_address;
    logic [N-1:0]      mem_writeData, mem_readData;

    // Memory seen by the DUT.
    logic [N-1:0] dmem [DEPTH];
    // Reference model state.
    logic [N-1:0] refMem [DEPTH];
    logic         refPending;
    logic [N-1:0] refRsp;
    int           refWait;

    int nAsserts = 0;
    int nFails   = 0;

    always #5 clk = ~clk;

    assign mem_readData = dmem[mem_address];
    always @(posedge clk) if (mem_writeEnable) dmem[mem_address] <= mem_writeData;

    dmem_arbiter #(.N(N), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_memRead     (cpuRead),
        .cpu_memWrite    (cpuWrite),
        .cpu_addr        (cpuAddr),
        .cpu_writeData   (cpuWdata),
        .cpu_readData    (cpu_readData),
        .cpu_stall       (cpu_stall),
        .dbg_req_valid   (dbgValid),
        .dbg_req_ready   (dbg_req_ready),
        .dbg_req_write   (dbgWrite),
        .dbg_req_addr    (dbgAddr),
        .dbg_req_wdata   (dbgWdata),
        .dbg_rsp_valid   (dbg_rsp_valid),
        .dbg_rsp_ready   (rspReady),
        .dbg_rsp_data    (dbg_rsp_data),
        .mem_writeEnable (mem_writeEnable),
        .mem_readEnable  (mem_readEnable),
        .mem_address     (mem_address),
        .mem_writeData   (mem_writeData),
        .mem_readData    (mem_readData)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        refPending = 1'b0;
        refRsp     = '0;
        refWait    = 0;
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    task automatic cycle(output logic rdy, output logic stl);
        logic              cpuAct, expGrant, wasPending;
        logic [ADDR_W-1:0] cw;
        #1;
        cpuAct   = cpuRead | cpuWrite;
        cw       = cpuAddr[ADDR_W+2:3];
        expGrant = !refPending && dbgValid && (!cpuAct || refWait == int'(MAX_WAIT));
        rdy      = dbg_req_ready;
        stl      = cpu_stall;
        check("req_ready", N'(dbg_req_ready), N'(expGrant));
        check("cpu_stall", N'(cpu_stall), N'(expGrant && cpuAct));
        check("mem_address", N'(mem_address), N'(expGrant ? dbgAddr : cw));
        check("mem_we", N'(mem_writeEnable), N'(expGrant ? dbgWrite : cpuWrite));
        check("mem_re", N'(mem_readEnable), N'(expGrant ? !dbgWrite : cpuRead));
        check("mem_wdata", mem_writeData, expGrant ? dbgWdata : cpuWdata);
        if (!expGrant)
            check("cpu_rdata", cpu_readData, refMem[cw]);
        else if (cpuAct)
            check("cpu_rdata_stalled", cpu_readData, '0);
        @(posedge clk);
        wasPending = refPending;
        if (expGrant) begin
            refRsp = dbgWrite ? '0 : refMem[dbgAddr];
            if (dbgWrite) refMem[dbgAddr] = dbgWdata;
            refPending = 1'b1;
        end else begin
            if (cpuWrite) refMem[cw] = cpuWdata;
            if (refPending && rspReady) refPending = 1'b0;
        end
        if (expGrant || !dbgValid)
            refWait = 0;
        else if (!wasPending && refWait < int'(MAX_WAIT))
            refWait++;
        #1;
        check("rsp_valid", N'(dbg_rsp_valid), N'(refPending));
        if (refPending) check("rsp_data", dbg_rsp_data, refRsp);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        cpuRead  = 1'b0;
        cpuWrite = 1'b0;
        dbgValid = 1'b0;
        dbgWrite = 1'b0;
        rspReady = 1'b0;
    endtask

    initial begin
        logic         rdy, stl;
        logic [N-1:0] oldVal;
        int           grantCycle;

        for (int i = 0; i < int'(DEPTH); i++) begin
            dmem[i]   = {$urandom, $urandom};
            refMem[i] = dmem[i];
        end
        resetModel();

        // Reset held with CPU and debug both requesting.
        reset    = 1'b0;
        cpuRead  = 1'b1;
        cpuWrite = 1'b0;
        cpuAddr  = 64'hFFFF_FFFF_FFFF_FF2F;
        cpuWdata = 64'h1111_2222_3333_4444;
        dbgValid = 1'b1;
        dbgWrite = 1'b1;
        dbgAddr  = 6'd5;
        dbgWdata = 64'hAAAA;
        rspReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("rst_rsp_valid", N'(dbg_rsp_valid), '0);
            check("rst_rsp_data", dbg_rsp_data, '0);
            check("rst_cpu_stall", N'(cpu_stall), '0);
            check("rst_req_ready", N'(dbg_req_ready), '0);
            check("rst_mem_address", N'(mem_address), 64'h25);
            check("rst_mem_re", N'(mem_readEnable), 64'h1);
            check("rst_cpu_rdata", cpu_readData, refMem[37]);
        end
        @(negedge clk);
        idleInputs();
        reset = 1'b1;

        // Debug write then read of word 5 with the CPU idle.
        dbgValid = 1'b1; dbgWrite = 1'b1; dbgAddr = 6'd5; dbgWdata = 64'hDEAD;
        cycle(rdy, stl);
        check("t2_wr_ready", N'(rdy), 64'h1);
        check("t2_wr_rsp", dbg_rsp_data, '0);
        dbgValid = 1'b0; rspReady = 1'b1;
        cycle(rdy, stl);
        dbgValid = 1'b1; dbgWrite = 1'b0; rspReady = 1'b0;
        cycle(rdy, stl);
        check("t2_rd_ready", N'(rdy), 64'h1);
        check("t2_rd_rsp", dbg_rsp_data, 64'hDEAD);
        dbgValid = 1'b0; rspReady = 1'b1;
        cycle(rdy, stl);

        // CPU reads every cycle; pending debug read is forced through on the 5th.
        cpuRead = 1'b1; cpuAddr = 64'h0000_0000_0000_0050;
        dbgValid = 1'b1; dbgWrite = 1'b0; dbgAddr = 6'd7; rspReady = 1'b0;
        grantCycle = 0;
        for (int i = 1; i <= 10 && grantCycle == 0; i++) begin
            cycle(rdy, stl);
            if (rdy) begin
                grantCycle = i;
                check("t3_forced_stall", N'(stl), 64'h1);
            end
        end
        check("t3_grant_cycle", N'(grantCycle), N'(MAX_WAIT + 1));

        // Response held while not consumed; no new grant meanwhile.
        cpuRead = 1'b0;
        oldVal  = dbg_rsp_data;
        for (int i = 0; i < 3; i++) begin
            cycle(rdy, stl);
            check("t4_ready_low", N'(rdy), '0);
            check("t4_rsp_stable", dbg_rsp_data, oldVal);
        end
        rspReady = 1'b1;
        cycle(rdy, stl);
        check("t4_ready_in_resp", N'(rdy), '0);
        rspReady = 1'b0;
        cycle(rdy, stl);
        check("t4_regrant", N'(rdy), 64'h1);
        dbgValid = 1'b0; rspReady = 1'b1;
        cycle(rdy, stl);

        // CPU store to word 3 colliding with a forced debug read of word 3.
        oldVal = refMem[3];
        cpuRead = 1'b1; cpuWrite = 1'b0; cpuAddr = 64'h40;
        dbgValid = 1'b1; dbgWrite = 1'b0; dbgAddr = 6'd3; rspReady = 1'b0;
        for (int i = 0; i < int'(MAX_WAIT); i++) cycle(rdy, stl);
        cpuRead = 1'b0; cpuWrite = 1'b1; cpuAddr = 64'h18; cpuWdata = 64'h1234;
        cycle(rdy, stl);
        check("t5_dbg_wins", N'(rdy), 64'h1);
        check("t5_cpu_stalled", N'(stl), 64'h1);
        check("t5_old_value", dbg_rsp_data, oldVal);
        dbgValid = 1'b0; rspReady = 1'b1;
        cycle(rdy, stl);
        check("t5_retry_stall", N'(stl), '0);
        check("t5_store_landed", dmem[3], 64'h1234);
        idleInputs();

        // Asynchronous reset in the middle of a response.
        dbgValid = 1'b1; dbgWrite = 1'b0; dbgAddr = 6'd9;
        cycle(rdy, stl);
        idleInputs();
        #2 reset = 1'b0;
        #1;
        check("t6_async_valid", N'(dbg_rsp_valid), '0);
        check("t6_async_data", dbg_rsp_data, '0);
        resetModel();
        @(negedge clk);
        reset = 1'b1;
        dbgValid = 1'b1; dbgWrite = 1'b0; dbgAddr = 6'd9;
        cycle(rdy, stl);
        check("t6_idle_after", N'(rdy), 64'h1);
        idleInputs();
        rspReady = 1'b1;
        cycle(rdy, stl);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cpuWrite = ($urandom_range(0, 3) == 0);
            cpuRead  = !cpuWrite && ($urandom_range(0, 2) == 0);
            cpuAddr  = {$urandom, $urandom};
            cpuWdata = {$urandom, $urandom};
            dbgValid = ($urandom_range(0, 1) == 1);
            dbgWrite = ($urandom_range(0, 1) == 1);
            dbgAddr  = ADDR_W'($urandom);
            dbgWdata = {$urandom, $urandom};
            rspReady = ($urandom_range(0, 2) != 0);
            cycle(rdy, stl);
        end

        for (int i = 0; i < int'(DEPTH); i++) check("final_mem", dmem[i], refMem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
